// File: rtl/division_sign_restore_if.sv
// division_sign_restore_if: request/result bundle between the divider and its sign-restoration stage.
interface division_sign_restore_if;
  logic       start;
  logic [3:0] q_mag;
  logic [3:0] r_mag;
  logic       a_sign;
  logic       b_sign;
  logic [3:0] q;
  logic [3:0] r;
  logic       busy;
  logic       done;
  logic       ovf;
  modport master (output start, q_mag, r_mag, a_sign, b_sign, input q, r, busy, done, ovf);
  modport slave (input start, q_mag, r_mag, a_sign, b_sign, output q, r, busy, done, ovf);
endinterface

// File: rtl/division_sign_restore.sv
// division_sign_restore: reapplies operand signs to divider magnitudes using one shared negation adder.
module division_sign_restore (
  input logic                    clk,
  input logic                    rst,
  division_sign_restore_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CONV_Q, CONV_R, DONE} state_t;
  state_t     state_q, state_d;
  logic [3:0] qm_q, rm_q, q_q, r_q, q_d, r_d, src, neg;
  logic       as_q, bs_q, done_q, ovf_q, done_d, ovf_d, take, q_neg, q_ovf, r_ovf;
  // DONE also accepts start so a held request restarts with a 3-cycle cadence
  assign take = bus.start && (state_q == IDLE || state_q == DONE);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      qm_q    <= '0;
      rm_q    <= '0;
      as_q    <= 1'b0;
      bs_q    <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      if (take) begin
        qm_q <= bus.q_mag;
        rm_q <= bus.r_mag;
        as_q <= bus.a_sign;
        bs_q <= bus.b_sign;
      end
    end
  always_comb
    state_d = take ? CONV_Q : state_q == CONV_Q ? CONV_R : state_q == CONV_R ? DONE : IDLE;
  always_comb begin
    src    = state_q == CONV_R ? rm_q : qm_q;
    neg    = (src ^ 4'hf) + 4'd1;
    q_neg  = as_q ^ bs_q;
    q_ovf  = q_neg ? qm_q > 4'd8 : qm_q[3];
    r_ovf  = as_q ? rm_q > 4'd8 : rm_q[3];
    q_d    = state_q == CONV_Q ? (q_neg ? neg : qm_q) : q_q;
    r_d    = state_q == CONV_R ? (as_q ? neg : rm_q) : r_q;
    done_d = state_q == CONV_R;
    ovf_d  = state_q == CONV_R ? (q_ovf | r_ovf) : take ? 1'b0 : ovf_q;
  end
  assign bus.q    = q_q;
  assign bus.r    = r_q;
  assign bus.busy = state_q != IDLE;
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;
endmodule
